// File: rtl/imm_sel_pipe_if.sv
// Handshake bundle for imm_sel_pipe: producer side (instruction/select
// offer) and consumer side (buffered immediate). The DUT takes the slave
// view; whoever drives the instruction and drains the result takes master.
interface imm_sel_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      imm_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, instr, imm_sel, out_ready,
    output in_ready, out_valid, out_imm, out_illegal
  );

  modport master (
    output in_valid, instr, imm_sel, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal
  );
endinterface

// File: rtl/imm_sel_pipe.sv
// imm_sel_pipe: decode-stage immediate generator. Extracts and
// sign-extends the I/S/B/J/U immediates straight from the raw instruction
// word, then parks the result in a 2-entry elastic buffer so decode and
// execute can stall independently. Illegal selects produce imm 0 with a
// flag and bump a saturating error counter.
// Optional feature macro: IMM_SEL_ZIMM_EN makes select 101 return the CSR
// zimm (zero-extended instr[19:15]); without it, 101 is illegal.
module imm_sel_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  imm_sel_pipe_if.slave        bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_B = 3'b010,
    SEL_J = 3'b011,
    SEL_U = 3'b100,
    SEL_Z = 3'b101
  } sel_e;

  // Buffer state: two slots, 1-bit pointers wrapping modulo 2, occupancy 0..2.
  logic [XLEN-1:0]      imm_mem_q [2];
  logic                 ill_mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [XLEN-1:0]      calc_imm;
  logic                 calc_ill;
  logic [31:0]          u_word;
  logic                 push;
  logic                 pop;

  // The opcode field never contributes to any immediate.
  logic                 unused_opcode;
  assign unused_opcode = ^bus.instr[6:0];

  // U-type is a full 32-bit value; extending from bit 31 also covers XLEN=64.
  assign u_word = {bus.instr[31:12], 12'b0};

  // Immediate extraction and sign extension for the offered instruction.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    calc_imm = '0;
    calc_ill = 1'b0;
    case (sel_e'(bus.imm_sel))
      SEL_I: calc_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
      SEL_S: calc_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25],
                         bus.instr[11:7]};
      SEL_B: calc_imm = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                         bus.instr[30:25], bus.instr[11:8], 1'b0};
      SEL_J: calc_imm = {{(XLEN-21){bus.instr[31]}}, bus.instr[31],
                         bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
      SEL_U: calc_imm = {{(XLEN-31){u_word[31]}}, u_word[30:0]};
`ifdef IMM_SEL_ZIMM_EN
      SEL_Z: calc_imm = {{(XLEN-5){1'b0}}, bus.instr[19:15]};
`endif
      default: begin
        calc_imm = '0;
        calc_ill = 1'b1;
      end
    endcase
  end

  // Handshake qualifiers; in_ready depends only on registered occupancy.
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Next-state for pointers, occupancy and the saturating error counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;

    // Flush drops the buffer but never hides an illegal select from err_cnt.
    if (push && calc_ill && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);

    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge value regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Buffer slots: written on an accepted, non-flushed push.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is reset on purpose: out_imm/out_illegal expose
    // the head slot directly and must read 0 out of reset, and two entries
    // are cheap to clear.
    if (!rst_n) begin
      imm_mem_q[0] <= '0;
      imm_mem_q[1] <= '0;
      ill_mem_q[0] <= 1'b0;
      ill_mem_q[1] <= 1'b0;
    end else if (push && !flush) begin
      imm_mem_q[wr_ptr_q] <= calc_imm;
      ill_mem_q[wr_ptr_q] <= calc_ill;
    end
  end

  assign bus.out_imm     = imm_mem_q[rd_ptr_q];
  assign bus.out_illegal = ill_mem_q[rd_ptr_q];
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_imm_sel_pipe.sv
// Directed bench for imm_sel_pipe (XLEN=64, ERR_CNT_W=8). Inputs change
// 1 ns after a rising edge; outputs are checked in the same slot.
module tb_imm_sel_pipe;
  localparam int XLEN      = 64;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [ERR_CNT_W-1:0] err_cnt;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  imm_sel_pipe_if #(.XLEN(XLEN)) bus ();

  imm_sel_pipe #(.XLEN(XLEN), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [2:0] sel);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.imm_sel  = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.instr = '0; bus.imm_sel = '0; bus.out_ready = 1'b0;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_imm !== 64'h0) begin n_fail++; $display("FAIL rst_out_imm got %h exp 0", bus.out_imm); end
    n_checks++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_out_illegal got %b exp 0", bus.out_illegal); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
  endtask

  // Back-to-back legal selects with out_ready high: one result per cycle.
  task automatic test_formats();
    logic [31:0] ins [5] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h800000B7, 32'h0080006F};
    logic [2:0]  sel [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
    logic [63:0] exp [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                             64'h0000000000000008, 64'hFFFFFFFF80000000,
                             64'h0000000000000008};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(ins[i], sel[i]);
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_valid got %b exp 1", i, bus.out_valid); end
      n_checks++; if (bus.out_imm !== exp[i]) begin n_fail++; $display("FAIL fmt%0d_imm got %h exp %h", i, bus.out_imm, exp[i]); end
      n_checks++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_illegal got %b exp 0", i, bus.out_illegal); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_drain_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    offer(32'h00100093, 3'b000);
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.out_imm !== 64'd1) begin n_fail++; $display("FAIL bp_head1 got %h exp 1", bus.out_imm); end
    offer(32'h00200093, 3'b000);
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b exp 0", bus.in_ready); end
    offer(32'h00300093, 3'b000);
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.out_imm !== 64'd1) begin n_fail++; $display("FAIL bp_held_head got %h exp 1", bus.out_imm); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_imm !== 64'd2) begin n_fail++; $display("FAIL bp_order2 got %h exp 2", bus.out_imm); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b exp 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_order3_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_imm !== 64'd3) begin n_fail++; $display("FAIL bp_order3 got %h exp 3", bus.out_imm); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    offer(32'h00100093, 3'b000); tick();
    offer(32'h00200093, 3'b000); tick();
    // Buffer full, so the push offered with flush is not accepted either.
    offer(32'h00300093, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_err_legal got %0d exp 0", err_cnt); end
    // Now empty: an illegal push in a flush cycle is dropped but still counted.
    offer(32'h00000000, 3'b110);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b exp 0", bus.out_valid); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL flush_err_illegal got %0d exp 1", err_cnt); end
  endtask

  task automatic test_illegal();
    int exp_cnt;
    bus.out_ready = 1'b1;
    offer(32'hFFFFFFFF, 3'b111);
    for (int k = 1; k <= 300; k++) begin
      tick();
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      n_checks++; if (bus.out_imm !== 64'h0 || bus.out_illegal !== 1'b1 || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL ill%0d got imm %h flag %b valid %b exp imm 0 flag 1 valid 1", k, bus.out_imm, bus.out_illegal, bus.out_valid);
      end
      n_checks++; if (err_cnt !== exp_cnt[7:0]) begin n_fail++; $display("FAIL ill%0d_cnt got %0d exp %0d", k, err_cnt, exp_cnt); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL ill_sat got %0d exp 255", err_cnt); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    offer(32'h00100093, 3'b000); tick();
    offer(32'h00200093, 3'b000); tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_err got %0d exp 0", err_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    offer(32'h000F5073, 3'b101);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL zimm_valid got %b exp 1", bus.out_valid); end
`ifdef IMM_SEL_ZIMM_EN
    n_checks++; if (bus.out_imm !== 64'h1E || bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL zimm got %h/%b exp 1e/0", bus.out_imm, bus.out_illegal); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL zimm_err got %0d exp 0", err_cnt); end
`else
    n_checks++; if (bus.out_imm !== 64'h0 || bus.out_illegal !== 1'b1) begin n_fail++; $display("FAIL zimm_off got %h/%b exp 0/1", bus.out_imm, bus.out_illegal); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL zimm_off_err got %0d exp 1", err_cnt); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
